// File: rtl/led_activity.sv
// Activity-indicator LED driver: stretches single-cycle event strobes into visible
// blinks, one blink FSM plus saturating pending counter per channel, shared tick divider.
module led_activity #(
  parameter int unsigned CLK_CNT_WIDTH = 24,
  parameter int unsigned CH_WIDTH      = 1,
  parameter int unsigned PEND_WIDTH    = 2,
  parameter int unsigned ON_TICKS      = 2,
  parameter int unsigned OFF_TICKS     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CLK_CNT_WIDTH-1:0] div,
  input  logic                     clr,
  input  logic [CH_WIDTH-1:0]      event_in,
  output logic [CH_WIDTH-1:0]      led_out,
  output logic [CH_WIDTH-1:0]      busy,
  output logic [CH_WIDTH-1:0]      overflow,
  output logic                     tick_out
);

  localparam int unsigned TCNT_WIDTH = 8;
  localparam logic [TCNT_WIDTH-1:0] ON_LAST  = TCNT_WIDTH'(ON_TICKS - 1);
  localparam logic [TCNT_WIDTH-1:0] OFF_LAST = TCNT_WIDTH'(OFF_TICKS - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [CLK_CNT_WIDTH-1:0] cnt;

  state_t                  state_q [CH_WIDTH];
  state_t                  state_d [CH_WIDTH];
  logic [TCNT_WIDTH-1:0]   tcnt_q  [CH_WIDTH];
  logic [TCNT_WIDTH-1:0]   tcnt_d  [CH_WIDTH];
  logic [PEND_WIDTH-1:0]   pend_q  [CH_WIDTH];
  logic [PEND_WIDTH-1:0]   pend_d  [CH_WIDTH];
  logic [CH_WIDTH-1:0]     consume_c;
  logic [CH_WIDTH-1:0]     led_d;
  logic [CH_WIDTH-1:0]     busy_d;
  logic [CH_WIDTH-1:0]     ovf_d;

  // Tick divider; a div lowered below cnt lets cnt run through all-ones and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= (cnt == div);
      if (cnt == div) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CLK_CNT_WIDTH'(1);
      end
    end
  end

  // Channel state registers; outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH_WIDTH); i++) begin
        state_q[i] <= ST_IDLE;
        tcnt_q[i]  <= '0;
        pend_q[i]  <= '0;
      end
      led_out  <= '0;
      busy     <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < int'(CH_WIDTH); i++) begin
        state_q[i] <= state_d[i];
        tcnt_q[i]  <= tcnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      led_out  <= led_d;
      busy     <= busy_d;
      overflow <= ovf_d;
    end
  end

  // Per-channel next-state, pending-count and output logic.
  always_comb begin
    consume_c = '0;
    led_d     = '0;
    busy_d    = '0;
    ovf_d     = overflow;
    for (int i = 0; i < int'(CH_WIDTH); i++) begin
      state_d[i] = state_q[i];
      tcnt_d[i]  = tcnt_q[i];
      pend_d[i]  = pend_q[i];

      case (state_q[i])
        ST_IDLE: begin
          if (event_in[i] || (pend_q[i] != '0)) begin
            state_d[i]   = ST_ON;
            tcnt_d[i]    = '0;
            consume_c[i] = 1'b1;
          end
        end
        ST_ON: begin
          if (tick_out) begin
            if (tcnt_q[i] == ON_LAST) begin
              state_d[i] = ST_GAP;
              tcnt_d[i]  = '0;
            end else begin
              tcnt_d[i] = tcnt_q[i] + TCNT_WIDTH'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick_out) begin
            if (tcnt_q[i] == OFF_LAST) begin
              state_d[i] = ST_IDLE;
              tcnt_d[i]  = '0;
            end else begin
              tcnt_d[i] = tcnt_q[i] + TCNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          tcnt_d[i]  = '0;
        end
      endcase

      // An event paired with a consume nets to zero; an idle event with pend=0 is taken directly.
      if (event_in[i] && !consume_c[i]) begin
        if (pend_q[i] == PEND_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PEND_WIDTH'(1);
        end
      end else if (!event_in[i] && consume_c[i]) begin
        pend_d[i] = pend_q[i] - PEND_WIDTH'(1);
      end

      if (clr) begin
        state_d[i] = ST_IDLE;
        tcnt_d[i]  = '0;
        pend_d[i]  = '0;
        ovf_d[i]   = 1'b0;
      end

      led_d[i]  = (state_d[i] == ST_ON);
      busy_d[i] = (state_d[i] != ST_IDLE) || (pend_d[i] != '0);
    end
  end

endmodule

// File: tb/tb_led_activity.sv
// Directed bench for led_activity: blink timing, pending/overflow, clr and reset behaviour.
module tb_led_activity;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] div;
  logic        clr;
  logic [0:0]  event_in;
  logic [0:0]  led_out;
  logic [0:0]  busy;
  logic [0:0]  overflow;
  logic        tick_out;

  int checks = 0;
  int errors = 0;

  led_activity dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div      (div),
    .clr      (clr),
    .event_in (event_in),
    .led_out  (led_out),
    .busy     (busy),
    .overflow (overflow),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until the channel is idle and dark; counts blinks and the shortest dark run between blinks.
  task automatic count_blinks(input int budget, output int n, output int min_dark, output bit timed_out);
    logic prev;
    int   dark;
    n = 0; prev = 1'b0; dark = 0; min_dark = 1000; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (led_out[0] && !prev) begin
        n++;
        if (n > 1 && dark < min_dark) min_dark = dark;
      end
      if (!led_out[0]) dark++; else dark = 0;
      prev = led_out[0];
      if (!busy[0] && !led_out[0]) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; div = 24'd0; clr = 1'b0; event_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", led_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_out); end
    rst_n = 1'b1;
    step();
    checks++; if (tick_out !== 1'b1) begin errors++; $display("FAIL div0_first_tick: got %b expected 1", tick_out); end
    step();
    checks++; if (tick_out !== 1'b1) begin errors++; $display("FAIL div0_tick2: got %b expected 1", tick_out); end
    // cnt is 0 right after a tick, so switching div here is safe
    div = 24'd3;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step(); n++;
      if (tick_out) break;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL tick_period: got %0d expected 4", n); end
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step(); n++;
      if (tick_out) break;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL tick_period2: got %0d expected 4", n); end
  endtask

  task automatic test_single();
    int on_len, gap_len;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", led_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    on_len = 0;
    while (led_out[0] && on_len < 50) begin on_len++; step(); end
    checks++; if (on_len < 5 || on_len > 8) begin errors++; $display("FAIL single_on_len: got %0d expected 5..8", on_len); end
    gap_len = 0;
    while (!led_out[0] && busy[0] && gap_len < 50) begin gap_len++; step(); end
    checks++; if (gap_len < 5 || gap_len > 8) begin errors++; $display("FAIL single_gap_len: got %0d expected 5..8", gap_len); end
    checks++; if (busy !== 1'b0 || led_out !== 1'b0) begin errors++; $display("FAIL single_end_idle: got busy=%b led=%b expected 0 0", busy, led_out); end
  endtask

  task automatic test_back_to_back();
    int n, md;
    bit to;
    event_in = 1'b1;
    repeat (3) step();
    event_in = 1'b0;
    count_blinks(500, n, md, to);
    checks++; if (to || n !== 3) begin errors++; $display("FAIL b2b_blinks: got %0d (timeout=%0b) expected 3", n, to); end
    checks++; if (md < 6 || md > 9) begin errors++; $display("FAIL b2b_dark: got %0d expected 6..9", md); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int n, md;
    bit to;
    event_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early_%0d: got %b expected 0", k, overflow); end
    end
    step();
    event_in = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    count_blinks(800, n, md, to);
    checks++; if (to || n !== 4) begin errors++; $display("FAIL ovf_blinks: got %0d (timeout=%0b) expected 4", n, to); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_gap_boundary();
    int n, md, t, guard;
    bit to;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    guard = 0;
    while (led_out[0] && guard < 50) begin guard++; step(); end
    // the second tick seen in the gap is the GAP-to-IDLE cycle
    t = 0; guard = 0;
    while (guard < 50) begin
      if (tick_out) t++;
      if (t == 2) break;
      guard++; step();
    end
    checks++; if (t !== 2 || led_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_sync: got ticks=%0d led=%b busy=%b expected 2 0 1", t, led_out, busy); end
    event_in = 1'b1;
    step();
    checks++; if (led_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_idle_cycle: got led=%b busy=%b expected 0 1", led_out, busy); end
    step();
    event_in = 1'b0;
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL gap_relight: got %b expected 1", led_out); end
    count_blinks(500, n, md, to);
    checks++; if (to || n !== 2) begin errors++; $display("FAIL gap_blinks: got %0d (timeout=%0b) expected 2", n, to); end
  endtask

  task automatic test_clr();
    int guard, lit;
    guard = 0;
    while (!tick_out && guard < 20) begin guard++; step(); end
    event_in = 1'b1;
    repeat (3) step();
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL clr_pre_on: got %b expected 1", led_out); end
    clr = 1'b1;
    step();
    clr = 1'b0; event_in = 1'b0;
    checks++; if (led_out !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_state: got led=%b busy=%b ovf=%b expected 0 0 0", led_out, busy, overflow); end
    checks++; if (tick_out !== 1'b1) begin errors++; $display("FAIL clr_tick_phase4: got %b expected 1", tick_out); end
    step();
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL clr_tick_phase5: got %b expected 0", tick_out); end
    repeat (3) step();
    checks++; if (tick_out !== 1'b1) begin errors++; $display("FAIL clr_tick_phase8: got %b expected 1", tick_out); end
    lit = 0;
    for (int c = 0; c < 40; c++) begin
      if (led_out[0] || busy[0]) lit++;
      step();
    end
    checks++; if (lit !== 0) begin errors++; $display("FAIL clr_no_blinks: got %0d active cycles expected 0", lit); end
  endtask

  task automatic test_reset_mid_on();
    int n, lit;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    step();
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL rst_pre_on: got %b expected 1", led_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (led_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got led=%b busy=%b expected 0 0", led_out, busy); end
    step();
    rst_n = 1'b1;
    n = 0; lit = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (led_out[0] || busy[0]) lit++;
      if (n == 0 && tick_out) n = c + 1;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rst_first_tick: got %0d expected 4", n); end
    checks++; if (lit !== 0) begin errors++; $display("FAIL rst_no_blinks: got %0d active cycles expected 0", lit); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_boundary();
    test_clr();
    test_reset_mid_on();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_activity.md
# led_activity

Activity-indicator driver: converts single-cycle logic events (UART byte done, FIFO overflow, error strobes) into human-visible LED blinks, the output-side counterpart of switch debouncing. Each channel has its own blink FSM and a saturating pending-event counter, so event bursts become a countable train of blinks. All channels share one slow tick derived from a programmable divider. The block sits between status strobes and the board LED pins.

## Interface
- CLK_CNT_WIDTH, 24: width of the tick divider counter and `div`
- CH_WIDTH, 1: number of independent channels
- PEND_WIDTH, 2: pending-event counter width per channel; saturates at 2^PEND_WIDTH-1
- ON_TICKS, 2: LED-on length in ticks, legal range 1..255
- OFF_TICKS, 2: forced dark gap after each blink in ticks, legal range 1..255

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- div  in  CLK_CNT_WIDTH  tick period minus one, in clk cycles
- clr  in  1  synchronous clear of all channel state
- event_in  in  CH_WIDTH  per-channel event strobe; each clk cycle high counts as one event
- led_out  out  CH_WIDTH  registered LED drive, 1 = lit
- busy  out  CH_WIDTH  channel not idle or events pending
- overflow  out  CH_WIDTH  sticky: an event was dropped at saturation
- tick_out  out  1  registered one-cycle tick strobe

## Operation
- Divider: `cnt` counts 0..div, then wraps to 0. `tick_out <= (cnt == div)`. div = 0 gives tick_out high every cycle. A change to `div` while running takes effect on the next compare. If `div` is lowered below the current `cnt`, the counter runs to all-ones and wraps; this is accepted.
- Per-channel FSM, states IDLE, ON, GAP. 8-bit tick counter `tcnt`:
  - IDLE: if event_in or pend != 0, go to ON, clear tcnt, and consume one event.
  - ON: on each tick_out, tcnt++. On tick_out with tcnt == ON_TICKS-1, go to GAP and clear tcnt.
  - GAP: same rule with OFF_TICKS. On expiry go to IDLE.
- Pending counter: pend_next = pend + event - consume.
  - A simultaneous event and consume leaves pend unchanged.
  - At the maximum value with event and no consume, pend holds and overflow sets.
  - An event arriving in IDLE with pend = 0 is consumed directly. pend stays 0.
- Outputs:
  - led_out = (state == ON), registered.
  - busy = (state != IDLE) or (pend != 0), registered.
  - overflow clears only on reset or clr.
- clr: all channels go to IDLE, pend = 0, tcnt = 0, overflow = 0, led_out = 0. The divider is not affected. clr has priority over event_in in the same cycle; that event is dropped and does not set overflow.

## Timing
- Reset values: cnt = 0, tick_out = 0, and per channel state = IDLE, pend = 0, tcnt = 0, led_out = 0, busy = 0, overflow = 0.
- Reset asserted mid-blink extinguishes the LED immediately (asynchronous). Pending events are lost.
- Event to LED latency: led_out rises on the clock edge after the event cycle (1 cycle) when the channel is IDLE.
- ON length, with P = div+1: between (ON_TICKS-1)*P+1 and ON_TICKS*P cycles, depending on tick phase. GAP length follows the same rule with OFF_TICKS.
- After GAP expires there is exactly 1 IDLE cycle before the next pending blink starts.
- First tick_out after reset release: cycle div+1 (div = 0: cycle 1).
- Channels are fully independent. Simultaneous events on all channels are all accepted.

## Test plan
- div=3, single event pulse on ch0 at idle -> led_out[0] high 1 cycle later. It stays high 5..8 cycles, is dark 5..8 cycles, then busy falls. tick_out period is 4 cycles.
- div=3, 3 back-to-back event cycles at idle -> first is consumed immediately and pend=2. Exactly 3 blinks follow, each separated by a dark gap. overflow stays 0.
- PEND_WIDTH=2, 5 consecutive event cycles at idle -> 1 consumed and pend saturates at 3. overflow sets on the 5th event. Exactly 4 blinks result. overflow remains 1 afterwards.
- Event in the same cycle as the GAP-to-IDLE transition and in the IDLE consume cycle -> pend net unchanged in the consume cycle. No event is lost, verified by counting blinks.
- clr asserted mid-ON with pend=2 and event_in=1 in the same cycle -> next cycle led_out=0, busy=0, overflow=0. No further blinks. tick_out phase is unaffected.
- rst_n pulsed low mid-ON -> led_out drops without a clock edge. After release there are no blinks, and the first tick_out appears at cycle div+1.
